// File: rtl/collision_pkg.sv
// Shared types and constants for the collision manager slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package collision_pkg;

    typedef enum logic [1:0] {
        DRIVING  = 2'd0,
        SKIDDING = 2'd1,
        CRASHED  = 2'd2,
        RESPAWN  = 2'd3
    } player_state_t;

    // Bit positions inside the evaluated hit vector
    localparam int HIT_CRASH = 0;
    localparam int HIT_CAR   = 1;
    localparam int HIT_OIL   = 2;
    localparam int HIT_FUEL  = 3;
    localparam int NUM_HITS  = 4;

    // Default durations, in frames
    localparam int DEF_SKID_FRAMES   = 32;
    localparam int DEF_CRASH_FRAMES  = 60;
    localparam int DEF_INVULN_FRAMES = 90;

endpackage

// File: rtl/collision_manager_if.sv
// Bundles the drawing-request inputs and game-event outputs of the collision manager.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or single-cycle pulse.
interface collision_manager_if;

    logic       startOfFrame;
    logic       player_DR;
    logic       car_DR;
    logic       truck_DR;
    logic       fuel_DR;
    logic       oil_DR;
    logic       border_DR;
    logic [1:0] player_state;
    logic       crash_pulse;
    logic       skid_pulse;
    logic       fuel_pulse;
    logic       freeze_scroll;
    logic       invulnerable;

    // Video/drawing side that feeds requests and consumes events
    modport master (
        output startOfFrame, player_DR, car_DR, truck_DR, fuel_DR, oil_DR, border_DR,
        input  player_state, crash_pulse, skid_pulse, fuel_pulse, freeze_scroll, invulnerable
    );

    // Collision manager itself
    modport slave (
        input  startOfFrame, player_DR, car_DR, truck_DR, fuel_DR, oil_DR, border_DR,
        output player_state, crash_pulse, skid_pulse, fuel_pulse, freeze_scroll, invulnerable
    );

endinterface

// File: rtl/frame_hit_latch.sv
// Sticky per-frame overlap flags; eval_hits = latched flags OR this cycle's overlaps.
// Latency: a pixel hit is held from the next edge; eval_hits is combinational.
// Backpressure: none; flags clear on every startOfFrame.
module frame_hit_latch
    import collision_pkg::*;
(
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                player_DR,
    input  logic                car_DR,
    input  logic                truck_DR,
    input  logic                fuel_DR,
    input  logic                oil_DR,
    input  logic                border_DR,
    output logic [NUM_HITS-1:0] eval_hits
);

    logic [NUM_HITS-1:0] cur_hits;
    logic [NUM_HITS-1:0] flags_q;

    // Overlaps of the player car with each object class in the current pixel
    always_comb begin
        cur_hits            = '0;
        cur_hits[HIT_CRASH] = player_DR & (truck_DR | border_DR);
        cur_hits[HIT_CAR]   = player_DR & car_DR;
        cur_hits[HIT_OIL]   = player_DR & oil_DR;
        cur_hits[HIT_FUEL]  = player_DR & fuel_DR;
    end

    // A hit on the startOfFrame pixel still counts toward the frame that is ending
    assign eval_hits = flags_q | cur_hits;

    // Accumulate during the frame, clear when the frame is evaluated
    always_ff @(posedge clk) begin
        if (!resetN) begin
            flags_q <= '0;
        end else if (startOfFrame) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_q | cur_hits;
        end
    end

endmodule

// File: rtl/collision_manager.sv
// Resolves per-frame collisions into events and runs the drive/skid/crash/respawn sequence.
// Latency: state and pulses update on the edge after the startOfFrame cycle.
// Backpressure: none; pulses are one cycle wide and must be consumed when seen.
module collision_manager
    import collision_pkg::*;
#(
    parameter int SKID_FRAMES   = DEF_SKID_FRAMES,
    parameter int CRASH_FRAMES  = DEF_CRASH_FRAMES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic                clk,
    input  logic                resetN,
    collision_manager_if.slave  bus
);

    // Counter reload values: a state lasts exactly its duration because
    // expiry happens on the startOfFrame that finds the counter at zero.
    localparam logic [7:0] SKID_LOAD   = 8'(SKID_FRAMES - 1);
    localparam logic [7:0] CRASH_LOAD  = 8'(CRASH_FRAMES - 1);
    localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES - 1);

    logic [NUM_HITS-1:0] eval_hits;
    player_state_t       state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                crash_q, crash_d;
    logic                skid_q, skid_d;
    logic                fuel_q, fuel_d;
    logic                any_skid_hit;

    frame_hit_latch u_hit_latch (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (bus.startOfFrame),
        .player_DR    (bus.player_DR),
        .car_DR       (bus.car_DR),
        .truck_DR     (bus.truck_DR),
        .fuel_DR      (bus.fuel_DR),
        .oil_DR       (bus.oil_DR),
        .border_DR    (bus.border_DR),
        .eval_hits    (eval_hits)
    );

    assign any_skid_hit = eval_hits[HIT_CAR] | eval_hits[HIT_OIL];

    // Next state, counter and event pulses; nothing moves between frame starts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crash_d = 1'b0;
        skid_d  = 1'b0;
        fuel_d  = 1'b0;
        if (bus.startOfFrame) begin
            case (state_q)
                DRIVING: begin
                    if (eval_hits[HIT_CRASH]) begin
                        state_d = CRASHED;
                        cnt_d   = CRASH_LOAD;
                    end else if (any_skid_hit) begin
                        state_d = SKIDDING;
                        cnt_d   = SKID_LOAD;
                    end
                end
                SKIDDING: begin
                    // Further car/oil hits do not extend the skid
                    if (eval_hits[HIT_CRASH]) begin
                        state_d = CRASHED;
                        cnt_d   = CRASH_LOAD;
                    end else if (cnt_q == 8'd0) begin
                        state_d = DRIVING;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                CRASHED: begin
                    if (cnt_q == 8'd0) begin
                        state_d = RESPAWN;
                        cnt_d   = INVULN_LOAD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                RESPAWN: begin
                    if (cnt_q == 8'd0) begin
                        state_d = DRIVING;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = DRIVING;
                    cnt_d   = 8'd0;
                end
            endcase
            crash_d = (state_d == CRASHED)  && (state_q != CRASHED);
            skid_d  = (state_d == SKIDDING) && (state_q != SKIDDING);
            // Fuel is collectable everywhere except while, or when becoming, crashed
            fuel_d  = eval_hits[HIT_FUEL] && (state_q != CRASHED) && (state_d != CRASHED);
        end
    end

    // State, counter and registered event pulses
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= DRIVING;
            cnt_q   <= 8'd0;
            crash_q <= 1'b0;
            skid_q  <= 1'b0;
            fuel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crash_q <= crash_d;
            skid_q  <= skid_d;
            fuel_q  <= fuel_d;
        end
    end

    assign bus.player_state  = state_q;
    assign bus.crash_pulse   = crash_q;
    assign bus.skid_pulse    = skid_q;
    assign bus.fuel_pulse    = fuel_q;
    assign bus.freeze_scroll = (state_q == CRASHED);
    assign bus.invulnerable  = (state_q == RESPAWN);

endmodule
